// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, qualifies a synchronized lock,
// retries on lock timeout and latches a fault after repeated failures.
module pll_reset_ctrl #(
  parameter int unsigned RST_CYCLES          = 8,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       locked_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [7:0] relock_count_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

  logic        sync1_q;
  logic        lock_s;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d, retry_inc;
  logic [7:0]  relock_q, relock_d;
  logic        pll_rst_q, ready_q, fault_q;

  assign retry_inc = retry_q + 4'd1;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_q <= locked_i;
      lock_s  <= sync1_q;
    end
  end

  // Next-state, counter, retry and relock computation
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    if (restart_i) begin
      state_d = ST_ASSERT;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
          else                   state_d = ST_ASSERT;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TMO_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_ASSERT;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_READY;
            retry_d = 4'd0;
          end else begin
            state_d = ST_STABLE;
          end
        end
        ST_READY: begin
          if (!lock_s) begin
            state_d  = ST_ASSERT;
            relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_ASSERT;
      endcase
    end
    // Restart re-enters ASSERT even from ASSERT, so it also clears the counter
    if (restart_i || (state_d != state_q)) begin
      cnt_d = 16'd0;
    end else if (cnt_q == 16'hFFFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers; outputs are decoded from the next state so they change on the same edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= 16'd0;
      retry_q   <= 4'd0;
      relock_q  <= 8'd0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      relock_q  <= relock_d;
      pll_rst_q <= (state_d == ST_ASSERT) || (state_d == ST_FAULT);
      ready_q   <= (state_d == ST_READY);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst_o      = pll_rst_q;
  assign ready_o        = ready_q;
  assign fault_o        = fault_q;
  assign relock_count_o = relock_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: directed scenarios plus randomized lock
// traffic, every cycle compared against a phase/dwell-time reference model.
module tb_pll_reset_ctrl;
  localparam int RST  = 4;
  localparam int STB  = 16;
  localparam int TMO  = 100;
  localparam int MAXR = 3;
  localparam int P_ASSERT = 0, P_WAIT = 1, P_STABLE = 2, P_READY = 3, P_FAULT = 4;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       locked_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       pll_rst_o, ready_o, fault_o;
  logic [7:0] relock_count_o;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  int       m_phase, m_dwell, m_retries, m_losses;
  bit [1:0] m_lock_pipe;

  pll_reset_ctrl #(
    .RST_CYCLES(RST), .LOCK_STABLE_CYCLES(STB),
    .LOCK_TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .locked_i(locked_i), .restart_i(restart_i),
    .pll_rst_o(pll_rst_o), .ready_o(ready_o), .fault_o(fault_o),
    .relock_count_o(relock_count_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_ASSERT; m_dwell = 0; m_retries = 0; m_losses = 0; m_lock_pipe = 2'b00;
  endtask

  // Reference: each phase is left once its dwell time or the delayed lock says so
  task automatic model_edge(input bit lk, input bit rs);
    bit seen_lock;
    int next_phase;
    seen_lock  = m_lock_pipe[1];
    next_phase = m_phase;
    if (rs) begin
      next_phase = P_ASSERT;
      m_retries  = 0;
    end else if (m_phase == P_ASSERT) begin
      if (m_dwell + 1 >= RST) next_phase = P_WAIT;
    end else if (m_phase == P_WAIT) begin
      if (seen_lock) next_phase = P_STABLE;
      else if (m_dwell + 1 >= TMO) begin
        m_retries  = m_retries + 1;
        next_phase = (m_retries >= MAXR) ? P_FAULT : P_ASSERT;
      end
    end else if (m_phase == P_STABLE) begin
      if (!seen_lock) next_phase = P_WAIT;
      else if (m_dwell + 1 >= STB) begin
        next_phase = P_READY;
        m_retries  = 0;
      end
    end else if (m_phase == P_READY) begin
      if (!seen_lock) begin
        next_phase = P_ASSERT;
        m_losses   = (m_losses < 255) ? m_losses + 1 : 255;
      end
    end
    m_dwell     = (rs || next_phase != m_phase) ? 0 : m_dwell + 1;
    m_phase     = next_phase;
    m_lock_pipe = {m_lock_pipe[0], lk};
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".state"},   state_o, m_phase);
    chk({ph, ".pll_rst"}, pll_rst_o, (m_phase == P_ASSERT || m_phase == P_FAULT));
    chk({ph, ".ready"},   ready_o, (m_phase == P_READY));
    chk({ph, ".fault"},   fault_o, (m_phase == P_FAULT));
    chk({ph, ".relock"},  relock_count_o, m_losses);
    chk({ph, ".excl"},    ready_o & fault_o, 0);
  endtask

  task automatic cycle(input bit lk, input bit rs, input string ph);
    @(negedge clk_i);
    locked_i  = lk;
    restart_i = rs;
    @(posedge clk_i);
    model_edge(lk, rs);
    #1 compare_all(ph);
  endtask

  initial begin
    int n;
    int saved;
    model_reset();
    #12;
    chk("rst.state", state_o, 0);
    chk("rst.pll_rst", pll_rst_o, 1);
    chk("rst.ready", ready_o, 0);
    chk("rst.fault", fault_o, 0);
    chk("rst.relock", relock_count_o, 0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // Bring-up: reset pulse width, then lock latency to ready
    n = 0;
    for (int k = 0; k < 20 && (n == 0 || pll_rst_o); k++) begin
      cycle(1'b0, 1'b0, "pulse");
      n++;
    end
    chk("pulse_width", n, RST);
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, "wait_pre");
    n = 0;
    for (int k = 0; k < 40 && !ready_o; k++) begin
      cycle(1'b1, 1'b0, "bringup");
      n++;
    end
    chk("bringup_latency", n, 2 + STB + 1);
    chk("bringup_fault", fault_o, 0);

    // Stability glitch restarts qualification
    cycle(1'b1, 1'b1, "glitch_restart");
    for (int k = 0; k < 20 && m_phase != P_STABLE; k++) cycle(1'b1, 1'b0, "to_stable");
    for (int k = 0; k < 20 && m_dwell < 10; k++) cycle(1'b1, 1'b0, "stable_cnt");
    cycle(1'b0, 1'b0, "glitch");
    n = 0;
    for (int k = 0; k < 40 && !ready_o; k++) begin
      cycle(1'b1, 1'b0, "glitch_relock");
      n++;
    end
    chk("glitch_latency", n, 2 + STB + 1);

    // Restart coincident with lock loss in READY
    saved = relock_count_o;
    cycle(1'b0, 1'b0, "prio_a");
    cycle(1'b0, 1'b0, "prio_b");
    cycle(1'b0, 1'b1, "prio_c");
    chk("prio_relock", relock_count_o, saved);
    chk("prio_state", state_o, 0);

    // Repeated lock losses saturate the relock counter
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 60 && !ready_o; k++) cycle(1'b1, 1'b0, "relock_up");
      chk("relock_ready", ready_o, 1);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, "relock_drop");
      if (i == 0) begin
        chk("loss_ready", ready_o, 0);
        chk("loss_pll_rst", pll_rst_o, 1);
        chk("loss_count", relock_count_o, 1);
      end
    end
    chk("relock_sat", relock_count_o, 255);

    // Timeouts exhaust the retries and latch FAULT
    cycle(1'b0, 1'b1, "tmo_restart");
    for (int k = 0; k < MAXR * (RST + TMO) + 60; k++) cycle(1'b0, 1'b0, "timeout");
    chk("fault_state", state_o, 4);
    chk("fault_flag", fault_o, 1);
    chk("fault_pll_rst", pll_rst_o, 1);
    cycle(1'b0, 1'b1, "fault_restart");
    chk("restart_state", state_o, 0);
    chk("restart_fault", fault_o, 0);

    // Randomized lock traffic with occasional restarts
    for (int r = 0; r < 120; r++) begin
      bit lv;
      int len;
      lv  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 30);
      for (int k = 0; k < len; k++) cycle(lv, ($urandom_range(0, 199) == 0), "random");
    end

    // Asynchronous reset in the middle of WAIT_LOCK
    cycle(1'b0, 1'b1, "ar_restart");
    for (int k = 0; k < 60 && m_phase != P_WAIT; k++) cycle(1'b0, 1'b0, "ar_to_wait");
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, "ar_wait");
    #2 rst_n_i = 1'b0;
    #1;
    chk("ar.state", state_o, 0);
    chk("ar.pll_rst", pll_rst_o, 1);
    chk("ar.ready", ready_o, 0);
    chk("ar.fault", fault_o, 0);
    chk("ar.relock", relock_count_o, 0);
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    for (int k = 0; k < 40; k++) cycle(1'b1, 1'b0, "post_reset");
    chk("post_reset_ready", ready_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
